// File: rtl/segment_readback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : segment_readback                                                |
// | Purpose  : Debounced readback of a two-digit 7-segment panel to hex values |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module segment_readback #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment1_A,
  input  logic       i_Segment1_B,
  input  logic       i_Segment1_C,
  input  logic       i_Segment1_D,
  input  logic       i_Segment1_E,
  input  logic       i_Segment1_F,
  input  logic       i_Segment1_G,
  input  logic       i_Segment2_A,
  input  logic       i_Segment2_B,
  input  logic       i_Segment2_C,
  input  logic       i_Segment2_D,
  input  logic       i_Segment2_E,
  input  logic       i_Segment2_F,
  input  logic       i_Segment2_G,
  output logic [3:0] o_Hex_1,
  output logic [3:0] o_Hex_2,
  output logic       o_Valid_1,
  output logic       o_Valid_2,
  output logic       o_Update_1,
  output logic       o_Update_2,
  output logic       o_Err_1,
  output logic       o_Err_2,
  output logic [7:0] o_Err_Count
);

  // Accept on the edge where the counter has already seen STABLE_CYCLES-1 matches.
  localparam logic [15:0] C_LAST = 16'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns {legal, blank, value}; pattern bits are {A..G} with 1 = lit.
  function automatic logic [5:0] f_decode(input logic [6:0] pat);
    logic [5:0] v;
    v = 6'b00_0000;
    case (pat)
      7'h7E:   v = {2'b10, 4'h0};
      7'h30:   v = {2'b10, 4'h1};
      7'h6D:   v = {2'b10, 4'h2};
      7'h79:   v = {2'b10, 4'h3};
      7'h33:   v = {2'b10, 4'h4};
      7'h5B:   v = {2'b10, 4'h5};
      7'h5F:   v = {2'b10, 4'h6};
      7'h70:   v = {2'b10, 4'h7};
      7'h7F:   v = {2'b10, 4'h8};
      7'h7B:   v = {2'b10, 4'h9};
      7'h77:   v = {2'b10, 4'hA};
      7'h1F:   v = {2'b10, 4'hB};
      7'h4E:   v = {2'b10, 4'hC};
      7'h3D:   v = {2'b10, 4'hD};
      7'h4F:   v = {2'b10, 4'hE};
      7'h47:   v = {2'b10, 4'hF};
      7'h00:   v = {2'b01, 4'h0};
      default: v = 6'b00_0000;
    endcase
    return v;
  endfunction

  logic [13:0] w_pat_all;
  logic [7:0]  w_hex_all;
  logic [1:0]  w_valid_all;
  logic [1:0]  w_upd_all;
  logic [1:0]  w_err_all;
  logic [1:0]  w_err_evt;

  assign w_pat_all[6:0]  = ~{i_Segment1_A, i_Segment1_B, i_Segment1_C, i_Segment1_D,
                             i_Segment1_E, i_Segment1_F, i_Segment1_G};
  assign w_pat_all[13:7] = ~{i_Segment2_A, i_Segment2_B, i_Segment2_C, i_Segment2_D,
                             i_Segment2_E, i_Segment2_F, i_Segment2_G};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [6:0]  w_pat;
    logic [6:0]  r_pat;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_legal;
    logic        w_blank;
    logic [3:0]  w_dec;
    logic [3:0]  r_hex;
    logic        r_valid;
    logic        r_upd;
    logic        r_err;

    assign w_pat = w_pat_all[gi*7 +: 7];
    // On an accepting edge the live pattern equals r_pat, so decoding r_pat is exact.
    assign {w_legal, w_blank, w_dec} = f_decode(r_pat);

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      if (w_pat != r_pat) begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
      end else if (r_state == SETTLE) begin
        if (r_cnt == C_LAST) begin
          w_accept    = 1'b1;
          w_state_nxt = LOCKED;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
    end

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        r_pat   <= '0;
        r_cnt   <= '0;
        r_state <= SETTLE;
      end else begin
        r_pat   <= w_pat;
        r_cnt   <= w_cnt_nxt;
        r_state <= w_state_nxt;
      end
    end

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        r_hex   <= '0;
        r_valid <= 1'b0;
        r_upd   <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        r_upd <= w_accept & w_legal & (~r_valid | (w_dec != r_hex));
        r_err <= w_err_evt[gi];
        if (w_accept) begin
          r_valid <= w_legal;
          if (w_legal) begin
            r_hex <= w_dec;
          end
        end
      end
    end

    assign w_err_evt[gi]        = w_accept & ~w_legal & ~w_blank;
    assign w_hex_all[gi*4 +: 4] = r_hex;
    assign w_valid_all[gi]      = r_valid;
    assign w_upd_all[gi]        = r_upd;
    assign w_err_all[gi]        = r_err;
  end

  logic [7:0] r_err_count;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_err_evt[0]} + {8'd0, w_err_evt[1]};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end
  end

  assign o_Hex_1     = w_hex_all[3:0];
  assign o_Hex_2     = w_hex_all[7:4];
  assign o_Valid_1   = w_valid_all[0];
  assign o_Valid_2   = w_valid_all[1];
  assign o_Update_1  = w_upd_all[0];
  assign o_Update_2  = w_upd_all[1];
  assign o_Err_1     = w_err_all[0];
  assign o_Err_2     = w_err_all[1];
  assign o_Err_Count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_segment_readback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_segment_readback                                             |
// | Purpose  : Vector table, corner sequences and random run vs. a model       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_segment_readback;
  localparam int STABLE = 16;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [6:0] pat1 = 7'h00;
  logic [6:0] pat2 = 7'h00;
  logic [3:0] o_Hex_1, o_Hex_2;
  logic       o_Valid_1, o_Valid_2, o_Update_1, o_Update_2, o_Err_1, o_Err_2;
  logic [7:0] o_Err_Count;

  always #5 clk = ~clk;

  segment_readback #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l),
    .i_Segment1_A(~pat1[6]), .i_Segment1_B(~pat1[5]), .i_Segment1_C(~pat1[4]),
    .i_Segment1_D(~pat1[3]), .i_Segment1_E(~pat1[2]), .i_Segment1_F(~pat1[1]),
    .i_Segment1_G(~pat1[0]),
    .i_Segment2_A(~pat2[6]), .i_Segment2_B(~pat2[5]), .i_Segment2_C(~pat2[4]),
    .i_Segment2_D(~pat2[3]), .i_Segment2_E(~pat2[2]), .i_Segment2_F(~pat2[1]),
    .i_Segment2_G(~pat2[0]),
    .o_Hex_1(o_Hex_1), .o_Hex_2(o_Hex_2), .o_Valid_1(o_Valid_1), .o_Valid_2(o_Valid_2),
    .o_Update_1(o_Update_1), .o_Update_2(o_Update_2), .o_Err_1(o_Err_1), .o_Err_2(o_Err_2),
    .o_Err_Count(o_Err_Count)
  );

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a pattern is accepted on the STABLE-th consecutive edge it is re-seen.
  logic [6:0] m_prev [2];
  int         m_run  [2];
  logic [3:0] m_hex  [2];
  logic       m_val  [2];
  logic       m_upd  [2];
  logic       m_err  [2];
  int         m_cnt;

  function automatic int glyph_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [6:0] p [2];
    int g;
    p[0] = pat1;
    p[1] = pat2;
    if (!rst_l) begin
      for (int d = 0; d < 2; d++) begin
        m_prev[d] = 7'h00; m_run[d] = 0; m_hex[d] = 4'h0;
        m_val[d] = 1'b0; m_upd[d] = 1'b0; m_err[d] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_upd[d] = 1'b0;
        m_err[d] = 1'b0;
        if (p[d] != m_prev[d]) begin
          m_prev[d] = p[d];
          m_run[d]  = 0;
        end else begin
          m_run[d]++;
          if (m_run[d] == STABLE) begin
            g = glyph_index(p[d]);
            if (g >= 0) begin
              m_upd[d] = !m_val[d] || (m_hex[d] != 4'(g));
              m_hex[d] = 4'(g);
              m_val[d] = 1'b1;
            end else begin
              m_val[d] = 1'b0;
              if (p[d] != 7'h00) begin
                m_err[d] = 1'b1;
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
              end
            end
          end
        end
      end
    end
  end

  bit model_en = 1'b0;
  always @(negedge clk) begin
    if (model_en)
      check("model",
            {10'd0, o_Hex_1, o_Valid_1, o_Update_1, o_Err_1,
                    o_Hex_2, o_Valid_2, o_Update_2, o_Err_2, o_Err_Count},
            {10'd0, m_hex[0], m_val[0], m_upd[0], m_err[0],
                    m_hex[1], m_val[1], m_upd[1], m_err[1], 8'(m_cnt)});
  end

  int upd1_n, upd2_n, err1_n, err2_n;
  task automatic run(input int n);
    upd1_n = 0; upd2_n = 0; err1_n = 0; err2_n = 0;
    repeat (n) begin
      @(negedge clk);
      upd1_n += int'(o_Update_1);
      upd2_n += int'(o_Update_2);
      err1_n += int'(o_Err_1);
      err2_n += int'(o_Err_2);
    end
  endtask

  typedef struct {
    logic [6:0] p1, p2;
    int         n;
    logic [3:0] h1;
    logic       v1;
    logic [3:0] h2;
    logic       v2;
    int         u1, u2, e;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt, first_k, n_upd;
    tbl[0]  = '{7'h79, 7'h79, 120, 4'h3, 1'b1, 4'h3, 1'b1, 1, 1, 0};
    tbl[1]  = '{7'h5B, 7'h79,  40, 4'h5, 1'b1, 4'h3, 1'b1, 1, 0, 0};
    tbl[2]  = '{7'h5F, 7'h79,  10, 4'h5, 1'b1, 4'h3, 1'b1, 0, 0, 0};
    tbl[3]  = '{7'h5B, 7'h79,  30, 4'h5, 1'b1, 4'h3, 1'b1, 0, 0, 0};
    tbl[4]  = '{7'h5F, 7'h79,  20, 4'h6, 1'b1, 4'h3, 1'b1, 1, 0, 0};
    tbl[5]  = '{7'h01, 7'h79,  20, 4'h6, 1'b0, 4'h3, 1'b1, 0, 0, 1};
    tbl[6]  = '{7'h00, 7'h79,  20, 4'h6, 1'b0, 4'h3, 1'b1, 0, 0, 1};
    tbl[7]  = '{7'h7E, 7'h7E,  20, 4'h0, 1'b1, 4'h0, 1'b1, 1, 1, 1};
    tbl[8]  = '{7'h47, 7'h47,  20, 4'hF, 1'b1, 4'hF, 1'b1, 1, 1, 1};
    tbl[9]  = '{7'h7E, 7'h47,  20, 4'h0, 1'b1, 4'hF, 1'b1, 1, 0, 1};
    tbl[10] = '{7'h01, 7'h02,  20, 4'h0, 1'b0, 4'hF, 1'b0, 0, 0, 3};

    // Reset state
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex1", 32'(o_Hex_1), 0);
    check("rst_hex2", 32'(o_Hex_2), 0);
    check("rst_valid", 32'({o_Valid_1, o_Valid_2}), 0);
    check("rst_pulses", 32'({o_Update_1, o_Update_2, o_Err_1, o_Err_2}), 0);
    check("rst_errcnt", 32'(o_Err_Count), 0);
    model_en = 1'b1;
    rst_l = 1'b1;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      pat1 = tbl[i].p1;
      pat2 = tbl[i].p2;
      run(tbl[i].n);
      check($sformatf("v%0d_hex1", i), 32'(o_Hex_1), 32'(tbl[i].h1));
      check($sformatf("v%0d_val1", i), 32'(o_Valid_1), 32'(tbl[i].v1));
      check($sformatf("v%0d_hex2", i), 32'(o_Hex_2), 32'(tbl[i].h2));
      check($sformatf("v%0d_val2", i), 32'(o_Valid_2), 32'(tbl[i].v2));
      check($sformatf("v%0d_upd1", i), 32'(upd1_n), 32'(tbl[i].u1));
      check($sformatf("v%0d_upd2", i), 32'(upd2_n), 32'(tbl[i].u2));
      check($sformatf("v%0d_errcnt", i), 32'(o_Err_Count), 32'(tbl[i].e));
    end

    // Walk digit 2 through every glyph, then wrap F -> 0
    pat1 = 7'h7E;
    for (int v = 0; v < 16; v++) begin
      pat2 = glyph[v];
      run(20);
      check($sformatf("walk%0d_upd2", v), 32'(upd2_n), 1);
      check($sformatf("walk%0d_hex2", v), 32'(o_Hex_2), 32'(v));
    end
    pat2 = 7'h7E;
    run(20);
    check("wrap_upd2", 32'(upd2_n), 1);
    check("wrap_hex2", 32'(o_Hex_2), 0);
    check("walk_errcnt", 32'(o_Err_Count), 3);

    // Error counter saturation with both digits erroring on the same edge
    exp_cnt = 3;
    for (int r = 0; r < 150; r++) begin
      pat1 = (r % 2 == 0) ? 7'h01 : 7'h02;
      pat2 = pat1;
      run(20);
      exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
      check($sformatf("sat%0d_errcnt", r), 32'(o_Err_Count), 32'(exp_cnt));
    end
    check("sat_err_pulses", 32'(err1_n + err2_n), 2);

    // Reset mid-settle on glyph 9 with cnt at 10
    pat1 = 7'h7B;
    pat2 = 7'h7B;
    repeat (11) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          {10'd0, o_Hex_1, o_Valid_1, o_Update_1, o_Err_1,
                  o_Hex_2, o_Valid_2, o_Update_2, o_Err_2, o_Err_Count}, 0);
    rst_l = 1'b1;
    first_k = -1;
    n_upd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_Update_1) begin
        n_upd++;
        if (first_k < 0) first_k = k;
      end
    end
    check("midrst_accept_edge", 32'(first_k), 17);
    check("midrst_upd_count", 32'(n_upd), 1);
    check("midrst_hex1", 32'(o_Hex_1), 9);

    // Randomized run against the model
    for (int s = 0; s < 300; s++) begin
      int sel;
      for (int d = 0; d < 2; d++) begin
        logic [6:0] p;
        sel = int'($urandom_range(0, 11));
        if (sel <= 5)       p = glyph[$urandom_range(0, 15)];
        else if (sel == 6)  p = 7'h00;
        else if (sel <= 9)  p = 7'($urandom);
        else                p = (d == 0) ? pat1 : pat2;
        if (d == 0) pat1 = p; else pat2 = p;
      end
      rst_l = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      rst_l = 1'b1;
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end

    model_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_readback.md
# segment_readback

Display readback receiver for the two-digit seven-segment panel. It samples the 14 active-low segment pins that drive the display and filters out patterns that have not been stable long enough. Each stable pattern is decoded back to a hex digit per display, with change and error events reported. It sits beside the display driver on the same clock and is used for self-check and board bring-up.

## Interface
- STABLE_CYCLES, 16, consecutive cycles a pattern must be held before acceptance; legal range 2..65535; 16-bit counter.
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  synchronous reset, active-low.
- i_Segment1_A .. i_Segment1_G  input  1 each  digit-1 segment pins, active-low (0 = lit).
- i_Segment2_A .. i_Segment2_G  input  1 each  digit-2 segment pins, active-low.
- o_Hex_1, o_Hex_2  output  4  last accepted valid digit value.
- o_Valid_1, o_Valid_2  output  1  last accepted pattern was a legal hex glyph.
- o_Update_1, o_Update_2  output  1  one-cycle pulse when a newly accepted valid value differs from the held value, or when valid goes 0->1.
- o_Err_1, o_Err_2  output  1  one-cycle pulse when an illegal, non-blank pattern is accepted.
- o_Err_Count  output  8  total illegal acceptances across both digits; saturates at 255.

## Operation
- Pattern word per digit: pat[6:0] = {~A, ~B, ~C, ~D, ~E, ~F, ~G}, with 1 = lit.
- Legal glyphs (pat hex -> digit):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F
- Blank is 00. Every other value is illegal.
- Each digit has an independent channel with a capture register r_pat, a counter cnt, and a state in {SETTLE, LOCKED}.
- Every edge, if pat != r_pat:
  - r_pat <= pat, cnt <= 0, state <= SETTLE.
  - This applies from either state and overrides everything else.
- SETTLE, pat == r_pat:
  - If cnt == STABLE_CYCLES-1, accept and go to LOCKED.
  - Otherwise cnt <= cnt+1.
- LOCKED, pat == r_pat: hold. No further acceptance until the pattern changes.
- Accept, by pattern class:
  - Legal: o_Hex <= decoded value, o_Valid <= 1. o_Update pulses if o_Valid was 0 or the decoded value != o_Hex.
  - Blank: o_Valid <= 0, o_Hex holds. No update pulse, no error pulse.
  - Illegal: o_Valid <= 0, o_Hex holds, o_Err pulses, o_Err_Count increments.
- While settling, o_Hex and o_Valid keep their last accepted values. A glitch shorter than STABLE_CYCLES is invisible at the outputs.
- If both digits accept an illegal pattern on the same edge, o_Err_Count increases by 2, saturating at 255; it never wraps.
- Re-accepting the value already held (e.g. 5 -> glitch -> 5) produces no o_Update pulse.

## Timing
- Reset (i_Rst_L = 0 at an edge) forces:
  - o_Hex = 0, o_Valid = 0, o_Update = 0, o_Err = 0, o_Err_Count = 0
  - r_pat = 00, cnt = 0, state = SETTLE
- Reset overrides all other activity, including mid-settle; a partial count is discarded.
- Latency: pins change before edge E0, so r_pat loads at E0. Accept occurs at edge E0+STABLE_CYCLES. Outputs and pulses are visible in the cycle following that edge.
- The o_Update and o_Err pulses are high for exactly one cycle per acceptance.
- After reset with blank pins, the channel locks after STABLE_CYCLES with no pulses.
- After reset with a steady glyph present, acceptance occurs at edge STABLE_CYCLES+1 after reset release, because the first post-reset edge reloads r_pat.
- The two channels are fully independent and may pulse on the same cycle.

## Test plan
- Reset, then hold both digits at glyph 3 (pins = ~79) with STABLE_CYCLES = 16:
  - o_Hex_1 = o_Hex_2 = 3, o_Valid = 1, one o_Update pulse each, 16 cycles after r_pat load.
  - No further pulses during 100 stable cycles.
- Digit 1 locked at 5; drive 6 for 10 cycles, then 5 again:
  - o_Hex_1 stays 5, no o_Update_1.
  - Drive 6 for 16 cycles: o_Hex_1 = 6 with one pulse.
- Walk digit 2 through 0..F, each held 20 cycles:
  - 16 o_Update_2 pulses, with o_Hex_2 values 0..F in order.
  - Toggling F->0 shows no wrap artefacts.
- Hold digit 1 at illegal 01 for 20 cycles:
  - One o_Err_1 pulse, o_Valid_1 = 0, o_Hex_1 unchanged, o_Err_Count = 1.
  - Then blank for 20 cycles: no pulse, count still 1.
- Alternate illegal 01 / 02 on both digits, 20 cycles each, 150 rounds:
  - o_Err_Count rises in steps of 2 and sticks at 255.
- Assert i_Rst_L = 0 for one cycle at cnt = 10 while settling on glyph 9:
  - All outputs 0.
  - Acceptance of 9 occurs 17 edges after reset release with one o_Update pulse.
